nx1_tmode_boot: RTL

NX1_TMODE_BOOT -- requirements
Module: nx1_tmode_boot

---
 rtl/nx1_tmode_boot_if.sv | 26 ++
 rtl/nx1_tmode_boot.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nx1_tmode_boot_if.sv
// Bus/handshake bundle between the X1turbo boot sequencer and the CPU I/O bus.
// master = sequencer side, slave = bus/arbiter/host side.
interface nx1_tmode_boot_if;
   logic        I_START;
   logic        O_BUSRQ;
   logic        I_BUSAK;
   logic [15:0] O_A;
   logic [7:0]  O_D;
   logic        O_DOE;
   logic [7:0]  I_D;
   logic        O_WR;
   logic        O_RD;
   logic        O_BUSY;
   logic        O_DONE;
   logic        O_ERR;

   modport master (
      input  I_START, I_BUSAK, I_D,
      output O_BUSRQ, O_A, O_D, O_DOE, O_WR, O_RD, O_BUSY, O_DONE, O_ERR
   );

   modport slave (
      output I_START, I_BUSAK, I_D,
      input  O_BUSRQ, O_A, O_D, O_DOE, O_WR, O_RD, O_BUSY, O_DONE, O_ERR
   );
endinterface

// File: rtl/nx1_tmode_boot.sv
// Boot-time programming of X1turbo mode ports 1FD0/1FE0 via a bus-request I/O write sequence.
// Define NX1_TMODE_VERIFY_EN to read back and compare each written value.
module nx1_tmode_boot #(
   parameter int         def_X1TURBO   = 0,
   parameter logic [7:0] def_P1FD0_VAL = 8'h00,
   parameter logic [6:0] def_P1FE0_VAL = 7'h00,
   parameter int         STB_CYCLES    = 2
) (
   input  logic             CLK,
   input  logic             I_RESET,
   nx1_tmode_boot_if.master bus
);

   typedef enum logic [3:0] {
      IDLE,
      REQ,
      SETUP,
      STROBE,
      HOLD,
`ifdef NX1_TMODE_VERIFY_EN
      RSETUP,
      RSTROBE,
`endif
      NEXT,
      REL
   } state_t;

   localparam logic [3:0] STB_LAST = 4'(STB_CYCLES - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        idx, idx_nx;
   logic        err, err_nx;

   logic [15:0] entry_addr;
   logic [7:0]  entry_data;
   logic        owned;

   logic        busrq, doe, wr, rd, done;
   logic [15:0] a;
   logic [7:0]  d;

   assign entry_addr = idx ? 16'h1FE0 : 16'h1FD0;
   assign entry_data = idx ? {1'b0, def_P1FE0_VAL} : def_P1FD0_VAL;

`ifdef NX1_TMODE_VERIFY_EN
   // Bit 7 of 1FE0 reads back undefined, so only the low seven bits are compared.
   logic rd_match;
   assign rd_match = idx ? (bus.I_D[6:0] == def_P1FE0_VAL)
                         : (bus.I_D == def_P1FD0_VAL);
`else
   logic unused_d;
   assign unused_d = ^bus.I_D;
`endif

   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         err   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      err_nx   = err;
      owned    = 1'b0;
      busrq    = 1'b0;
      a        = 16'h0000;
      d        = 8'h00;
      doe      = 1'b0;
      wr       = 1'b0;
      rd       = 1'b0;
      done     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.I_START) begin
               err_nx   = 1'b0;
               idx_nx   = 1'b0;
               cnt_nx   = '0;
               // Plain X1 has no turbo ports: complete without touching the bus.
               state_nx = (def_X1TURBO == 0) ? REL : REQ;
            end
         end
         REQ: begin
            busrq = 1'b1;
            if (bus.I_BUSAK) state_nx = SETUP;
         end
         SETUP: begin
            owned    = 1'b1;
            busrq    = 1'b1;
            a        = entry_addr;
            d        = entry_data;
            doe      = 1'b1;
            cnt_nx   = '0;
            state_nx = STROBE;
         end
         STROBE: begin
            owned = 1'b1;
            busrq = 1'b1;
            a     = entry_addr;
            d     = entry_data;
            doe   = 1'b1;
            wr    = 1'b1;
            if (cnt == STB_LAST) begin
               cnt_nx   = '0;
               state_nx = HOLD;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         HOLD: begin
            owned = 1'b1;
            busrq = 1'b1;
            a     = entry_addr;
            d     = entry_data;
            doe   = 1'b1;
`ifdef NX1_TMODE_VERIFY_EN
            state_nx = RSETUP;
`else
            state_nx = NEXT;
`endif
         end
`ifdef NX1_TMODE_VERIFY_EN
         RSETUP: begin
            owned    = 1'b1;
            busrq    = 1'b1;
            a        = entry_addr;
            cnt_nx   = '0;
            state_nx = RSTROBE;
         end
         RSTROBE: begin
            owned = 1'b1;
            busrq = 1'b1;
            a     = entry_addr;
            rd    = 1'b1;
            if (cnt == STB_LAST) begin
               cnt_nx = '0;
               if (rd_match) begin
                  state_nx = NEXT;
               end else begin
                  err_nx   = 1'b1;
                  state_nx = REL;
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
`endif
         NEXT: begin
            owned    = 1'b1;
            busrq    = 1'b1;
            idx_nx   = idx + 1'b1;
            state_nx = idx ? REL : SETUP;
         end
         REL: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Losing the bus mid-sequence: kill drive this cycle and bail out.
      if (owned && !bus.I_BUSAK) begin
         doe      = 1'b0;
         wr       = 1'b0;
         rd       = 1'b0;
         err_nx   = 1'b1;
         cnt_nx   = '0;
         state_nx = REL;
      end
   end

   assign bus.O_BUSRQ = busrq;
   assign bus.O_A     = a;
   assign bus.O_D     = d;
   assign bus.O_DOE   = doe;
   assign bus.O_WR    = wr;
   assign bus.O_RD    = rd;
   assign bus.O_BUSY  = (state != IDLE);
   assign bus.O_DONE  = done;
   assign bus.O_ERR   = err;

endmodule
